// File: rtl/snac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// snac_pkg : shared types/constants for the SNES-pad SNAC responder
// Rev 1.0
// ---------------------------------------------------------------
package snac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LATCHED = 2'd1,
      ST_SHIFT   = 2'd2,
      ST_DONE    = 2'd3
   } snac_state_t;

   localparam int SNES_FRAME_BITS = 16;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   localparam logic [3:0] SNAC_DEFAULT_ID = 4'b1111;

   // Line level is low for a pressed button, so the button word is inverted.
   function automatic logic [SNES_FRAME_BITS-1:0] build_frame(
      input logic [3:0]  id,
      input logic [11:0] btn
   );
      return {id, ~btn};
   endfunction

endpackage
`default_nettype wire

// File: rtl/snac_pin_filter.sv
`default_nettype none
// ---------------------------------------------------------------
// snac_pin_filter : synchronizer + glitch filter, flags accepted level changes
// Rev 1.0
// ---------------------------------------------------------------
module snac_pin_filter #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   FILTER_CYCLES = 3,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_edge
);

   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_edge;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         r_sync[0] <= i_pin;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // A new level is accepted on the FILTER_CYCLES-th consecutive differing sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_level <= RESET_VAL;
         r_edge  <= 1'b0;
      end else if (w_sync == r_level) begin
         r_cnt   <= '0;
         r_edge  <= 1'b0;
      end else if (r_cnt == c_last) begin
         r_cnt   <= '0;
         r_level <= w_sync;
         r_edge  <= 1'b1;
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1);
         r_edge  <= 1'b0;
      end
   end

   assign o_level = r_level;
   assign o_edge  = r_edge;

endmodule
`default_nettype wire

// File: rtl/snac_snes_responder.sv
`default_nettype none
// ---------------------------------------------------------------
// snac_snes_responder : SNES-pad side of the SNAC link, answers LATCH/CLK with a 16-bit frame
// Rev 1.0
// ---------------------------------------------------------------
module snac_snes_responder
   import snac_pkg::*;
#(
   parameter int         SYNC_STAGES    = 2,
   parameter int         FILTER_CYCLES  = 3,
   parameter int         TIMEOUT_CYCLES = 96000,
   parameter logic [3:0] ID_BITS        = SNAC_DEFAULT_ID
) (
   input  logic        clk_sys,
   input  logic        reset_l_main,
   input  logic        i_ena,
   input  logic [11:0] btn_state,
   input  logic        snac_latch,
   input  logic        snac_clk,
   output logic        snac_data_out,
   output logic        snac_data_oe,
   output logic        busy,
   output logic        frame_done,
   output logic [4:0]  bit_count
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] c_tmo_max   = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [4:0]       c_last_bit  = 5'(SNES_FRAME_BITS - 1);
   localparam logic [4:0]       c_frame_len = 5'(SNES_FRAME_BITS);

   logic w_latch_lvl, w_latch_edge, w_latch_rise, w_latch_fall;
   logic w_clk_lvl, w_clk_edge, w_clk_rise;

   snac_state_t                r_state, w_state_nx;
   logic [SNES_FRAME_BITS-1:0] r_shift, w_shift_nx;
   logic [4:0]                 r_bit_count, w_bit_count_nx;
   logic                       r_frame_done, w_frame_done_nx;
   logic [TMO_W-1:0]           r_tmo, w_tmo_nx;
   logic                       r_data_oe;
   logic [SNES_FRAME_BITS-1:0] w_frame;

   snac_pin_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL     (1'b0)
   ) u_latch_filt (
      .clk     (clk_sys),
      .rst_n   (reset_l_main),
      .i_pin   (snac_latch),
      .o_level (w_latch_lvl),
      .o_edge  (w_latch_edge)
   );

   snac_pin_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VAL     (1'b1)
   ) u_clk_filt (
      .clk     (clk_sys),
      .rst_n   (reset_l_main),
      .i_pin   (snac_clk),
      .o_level (w_clk_lvl),
      .o_edge  (w_clk_edge)
   );

   assign w_latch_rise = w_latch_edge &  w_latch_lvl;
   assign w_latch_fall = w_latch_edge & ~w_latch_lvl;
   assign w_clk_rise   = w_clk_edge   &  w_clk_lvl;
   assign w_frame      = build_frame(ID_BITS, btn_state);

   always_ff @(posedge clk_sys or negedge reset_l_main) begin
      if (!reset_l_main) begin
         r_state      <= ST_IDLE;
         r_shift      <= '1;
         r_bit_count  <= '0;
         r_frame_done <= 1'b0;
         r_tmo        <= '0;
         r_data_oe    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_shift      <= w_shift_nx;
         r_bit_count  <= w_bit_count_nx;
         r_frame_done <= w_frame_done_nx;
         r_tmo        <= w_tmo_nx;
         r_data_oe    <= i_ena;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_shift_nx      = r_shift;
      w_bit_count_nx  = r_bit_count;
      w_frame_done_nx = 1'b0;
      w_tmo_nx        = r_tmo;

      // Idle timer only runs while a frame is being clocked out.
      if (w_latch_edge || w_clk_edge || r_state == ST_IDLE || r_state == ST_LATCHED) begin
         w_tmo_nx = '0;
      end else if (r_tmo != c_tmo_max) begin
         w_tmo_nx = r_tmo + TMO_W'(1);
      end

      if (!i_ena) begin
         w_state_nx     = ST_IDLE;
         w_bit_count_nx = '0;
         w_tmo_nx       = '0;
      end else if (w_latch_rise) begin
         // Latch wins over a coincident clk edge and aborts any frame in flight.
         w_state_nx     = ST_LATCHED;
         w_shift_nx     = w_frame;
         w_bit_count_nx = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
            end
            ST_LATCHED: begin
               if (w_latch_fall) begin
                  w_state_nx = ST_SHIFT;
               end else if (w_latch_lvl) begin
                  w_shift_nx = w_frame;
               end
            end
            ST_SHIFT: begin
               if (w_clk_rise) begin
                  w_shift_nx     = {1'b0, r_shift[SNES_FRAME_BITS-1:1]};
                  w_bit_count_nx = r_bit_count + 5'd1;
                  if (r_bit_count == c_last_bit) begin
                     w_state_nx      = ST_DONE;
                     w_frame_done_nx = 1'b1;
                  end
               end else if (r_tmo == c_tmo_max) begin
                  w_state_nx     = ST_IDLE;
                  w_bit_count_nx = '0;
               end
            end
            ST_DONE: begin
               if (r_tmo == c_tmo_max) begin
                  w_state_nx     = ST_IDLE;
                  w_bit_count_nx = '0;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end
   end

   assign snac_data_out = (r_state == ST_IDLE)        ? 1'b1 :
                          (r_bit_count >= c_frame_len) ? 1'b0 : r_shift[0];
   assign snac_data_oe  = r_data_oe;
   assign busy          = (r_state != ST_IDLE);
   assign frame_done    = r_frame_done;
   assign bit_count     = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_snac_snes_responder.sv
`default_nettype none
// Bench for snac_snes_responder: host-side LATCH/CLK driver with a frame model.
module tb_snac_snes_responder;

   localparam int         TB_TIMEOUT = 1000;
   localparam logic [3:0] TB_ID      = 4'b1111;

   logic        clk_sys = 1'b0;
   logic        reset_l_main;
   logic        i_ena;
   logic [11:0] btn_state;
   logic        snac_latch;
   logic        snac_clk;
   logic        snac_data_out;
   logic        snac_data_oe;
   logic        busy;
   logic        frame_done;
   logic [4:0]  bit_count;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;

   snac_snes_responder #(
      .SYNC_STAGES    (2),
      .FILTER_CYCLES  (3),
      .TIMEOUT_CYCLES (TB_TIMEOUT),
      .ID_BITS        (TB_ID)
   ) dut (
      .clk_sys       (clk_sys),
      .reset_l_main  (reset_l_main),
      .i_ena         (i_ena),
      .btn_state     (btn_state),
      .snac_latch    (snac_latch),
      .snac_clk      (snac_clk),
      .snac_data_out (snac_data_out),
      .snac_data_oe  (snac_data_oe),
      .busy          (busy),
      .frame_done    (frame_done),
      .bit_count     (bit_count)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (frame_done === 1'b1) fd_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Serial bit k of a SNES frame: 12 buttons (low = pressed), 4 ID bits, then low forever.
   function automatic logic exp_bit(input logic [11:0] btn, input int idx);
      logic [3:0] id;
      id = TB_ID;
      if (idx < 12) return ~btn[idx];
      if (idx < 16) return id[idx-12];
      return 1'b0;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic latch_pulse(input int len);
      snac_latch = 1'b1;
      cyc(len);
      snac_latch = 1'b0;
      cyc(10);
   endtask

   task automatic clk_pulse(input int lo, input int hi);
      snac_clk = 1'b0;
      cyc(lo);
      snac_clk = 1'b1;
      cyc(hi);
   endtask

   // Latch a frame and clock nclk bits, checking every bit against the model.
   task automatic run_frame(input logic [11:0] btn, input int nclk, input string name);
      int         fd0;
      int         hp;
      logic       e;
      logic [4:0] ebc;
      fd0       = fd_cnt;
      btn_state = btn;
      latch_pulse($urandom_range(4, 20));
      btn_state = 12'($urandom);
      checks++; if (snac_data_out !== exp_bit(btn, 0)) begin errors++;
         $display("FAIL %s bit0: got %b exp %b", name, snac_data_out, exp_bit(btn, 0)); end
      checks++; if (bit_count !== 5'd0 || busy !== 1'b1) begin errors++;
         $display("FAIL %s load state: bit_count %0d busy %b exp 0/1", name, bit_count, busy); end
      for (int k = 1; k <= nclk; k++) begin
         hp = $urandom_range(8, 15);
         clk_pulse(hp, hp);
         e   = exp_bit(btn, k);
         ebc = (k > 16) ? 5'd16 : 5'(k);
         checks++; if (snac_data_out !== e) begin errors++;
            $display("FAIL %s bit%0d: got %b exp %b", name, k, snac_data_out, e); end
         checks++; if (bit_count !== ebc) begin errors++;
            $display("FAIL %s bit_count after %0d clks: got %0d exp %0d", name, k, bit_count, ebc); end
      end
      checks++; if ((fd_cnt - fd0) !== ((nclk >= 16) ? 1 : 0)) begin errors++;
         $display("FAIL %s frame_done pulses: got %0d exp %0d", name, fd_cnt - fd0, (nclk >= 16) ? 1 : 0); end
   endtask

   task automatic test_reset();
      reset_l_main = 1'b0;
      i_ena        = 1'b1;
      btn_state    = 12'h000;
      snac_latch   = 1'b0;
      snac_clk     = 1'b1;
      cyc(4);
      checks++; if ({snac_data_out, snac_data_oe, busy, frame_done, bit_count} !== {4'b1000, 5'd0}) begin errors++;
         $display("FAIL reset values: got out=%b oe=%b busy=%b fd=%b bc=%0d exp 1/0/0/0/0",
                  snac_data_out, snac_data_oe, busy, frame_done, bit_count); end
      reset_l_main = 1'b1;
      cyc(1);
      checks++; if (snac_data_oe !== 1'b1) begin errors++;
         $display("FAIL reset oe after release: got %b exp 1", snac_data_oe); end
      cyc(10);
      checks++; if (busy !== 1'b0 || snac_data_out !== 1'b1) begin errors++;
         $display("FAIL reset idle: busy %b out %b exp 0/1", busy, snac_data_out); end
   endtask

   task automatic test_latency();
      btn_state = 12'h001;
      latch_pulse(6);
      snac_clk = 1'b0;
      cyc(8);
      snac_clk = 1'b1;
      cyc(5);
      checks++; if (bit_count !== 5'd0) begin errors++;
         $display("FAIL latency early: bit_count %0d exp 0", bit_count); end
      cyc(1);
      checks++; if (bit_count !== 5'd1 || snac_data_out !== exp_bit(12'h001, 1)) begin errors++;
         $display("FAIL latency edge: bit_count %0d out %b exp 1/%b", bit_count, snac_data_out, exp_bit(12'h001, 1)); end
   endtask

   task automatic test_glitch();
      logic [11:0] b;
      logic        prev;
      b = 12'($urandom);
      btn_state = b;
      latch_pulse(8);
      for (int k = 0; k < 3; k++) clk_pulse(8, 8);
      prev = snac_data_out;
      snac_clk = 1'b0;
      cyc(2);
      snac_clk = 1'b1;
      cyc(12);
      checks++; if (bit_count !== 5'd3 || snac_data_out !== prev) begin errors++;
         $display("FAIL glitch ignored: bit_count %0d out %b exp 3/%b", bit_count, snac_data_out, prev); end
      clk_pulse(4, 12);
      checks++; if (bit_count !== 5'd4 || snac_data_out !== exp_bit(b, 4)) begin errors++;
         $display("FAIL 4-cycle pulse: bit_count %0d out %b exp 4/%b", bit_count, snac_data_out, exp_bit(b, 4)); end
   endtask

   task automatic test_abort();
      btn_state = 12'h001;
      latch_pulse(8);
      for (int k = 0; k < 5; k++) clk_pulse(8, 8);
      checks++; if (bit_count !== 5'd5) begin errors++;
         $display("FAIL abort pre: bit_count %0d exp 5", bit_count); end
      run_frame(12'h010, 16, "abort_reload");
   endtask

   task automatic test_same_cycle();
      logic [11:0] b;
      b = 12'($urandom);
      btn_state = b;
      latch_pulse(8);
      for (int k = 0; k < 3; k++) clk_pulse(8, 8);
      snac_clk = 1'b0;
      cyc(8);
      snac_latch = 1'b1;
      snac_clk   = 1'b1;
      cyc(10);
      checks++; if (bit_count !== 5'd0 || busy !== 1'b1 || snac_data_out !== exp_bit(b, 0)) begin errors++;
         $display("FAIL latch+clk same cycle: bc %0d busy %b out %b exp 0/1/%b", bit_count, busy, snac_data_out, exp_bit(b, 0)); end
      snac_latch = 1'b0;
      cyc(10);
      clk_pulse(8, 8);
      checks++; if (bit_count !== 5'd1 || snac_data_out !== exp_bit(b, 1)) begin errors++;
         $display("FAIL after same-cycle reload: bc %0d out %b exp 1/%b", bit_count, snac_data_out, exp_bit(b, 1)); end
   endtask

   task automatic test_timeout();
      btn_state = 12'($urandom);
      latch_pulse(8);
      cyc(TB_TIMEOUT - 30);
      checks++; if (busy !== 1'b1) begin errors++;
         $display("FAIL timeout early: busy %b exp 1", busy); end
      cyc(50);
      checks++; if (busy !== 1'b0 || snac_data_out !== 1'b1 || bit_count !== 5'd0) begin errors++;
         $display("FAIL timeout shift: busy %b out %b bc %0d exp 0/1/0", busy, snac_data_out, bit_count); end
      run_frame(12'($urandom), 16, "pre_done_timeout");
      cyc(TB_TIMEOUT + 20);
      checks++; if (busy !== 1'b0 || snac_data_out !== 1'b1 || bit_count !== 5'd0) begin errors++;
         $display("FAIL timeout done: busy %b out %b bc %0d exp 0/1/0", busy, snac_data_out, bit_count); end
   endtask

   task automatic test_reset_mid();
      btn_state = 12'($urandom);
      latch_pulse(8);
      for (int k = 0; k < 8; k++) clk_pulse(8, 8);
      reset_l_main = 1'b0;
      #1;
      checks++; if ({snac_data_out, snac_data_oe, busy, frame_done, bit_count} !== {4'b1000, 5'd0}) begin errors++;
         $display("FAIL reset mid-frame: out=%b oe=%b busy=%b fd=%b bc=%0d exp 1/0/0/0/0",
                  snac_data_out, snac_data_oe, busy, frame_done, bit_count); end
      cyc(3);
      reset_l_main = 1'b1;
      cyc(5);
      run_frame(12'($urandom), 16, "after_reset");
   endtask

   task automatic test_ena();
      btn_state = 12'($urandom);
      latch_pulse(8);
      for (int k = 0; k < 4; k++) clk_pulse(8, 8);
      i_ena = 1'b0;
      cyc(1);
      checks++; if (snac_data_oe !== 1'b0 || busy !== 1'b0 || snac_data_out !== 1'b1 || bit_count !== 5'd0) begin errors++;
         $display("FAIL ena low: oe %b busy %b out %b bc %0d exp 0/0/1/0", snac_data_oe, busy, snac_data_out, bit_count); end
      i_ena = 1'b1;
      cyc(2);
      checks++; if (snac_data_oe !== 1'b1) begin errors++;
         $display("FAIL ena restore oe: got %b exp 1", snac_data_oe); end
   endtask

   initial begin
      test_reset();
      run_frame(12'h001, 16, "btn_B");
      run_frame(12'hFFF, 18, "all_pressed");
      test_latency();
      test_glitch();
      test_abort();
      test_same_cycle();
      for (int i = 0; i < 4; i++) run_frame(12'($urandom), 16 + $urandom_range(0, 2), "random");
      test_timeout();
      test_ena();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
